// File: rtl/freq_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives run/select; the slave (the divider) returns the divided clock and its status.
interface freq_div_prog_if #(
    parameter int unsigned CNT_W = 24
);
    logic             en;
    logic [1:0]       sel;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] div_act;

    modport master (
        output en,
        output sel,
        input  clk_out,
        input  tick,
        input  running,
        input  div_act
    );

    modport slave (
        input  en,
        input  sel,
        output clk_out,
        output tick,
        output running,
        output div_act
    );
endinterface

// File: rtl/freq_div_prog.sv
// Glitch-free programmable clock divider with four run-time half-period presets.
// Preset changes and stop requests are honoured only at half-period boundaries.
module freq_div_prog #(
    parameter int unsigned     CNT_W      = 24,
    parameter longint unsigned PRESET0    = 5,
    parameter longint unsigned PRESET1    = 5999999,
    parameter longint unsigned PRESET2    = 5999,
    parameter longint unsigned PRESET3    = 5,
    parameter int unsigned     PULSE_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    freq_div_prog_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;
    localparam bit PULSE = (PULSE_MODE != 0);

    // A preset that does not fit the counter would silently truncate, so refuse to elaborate.
    if (PRESET0 >= CNT_LIMIT || PRESET1 >= CNT_LIMIT ||
        PRESET2 >= CNT_LIMIT || PRESET3 >= CNT_LIMIT) begin : g_preset_range
        $error("freq_div_prog: every PRESETn must be below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] P0 = CNT_W'(PRESET0);
    localparam logic [CNT_W-1:0] P1 = CNT_W'(PRESET1);
    localparam logic [CNT_W-1:0] P2 = CNT_W'(PRESET2);
    localparam logic [CNT_W-1:0] P3 = CNT_W'(PRESET3);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] counter_q, counter_nxt;
    logic [CNT_W-1:0] div_act_q, div_act_nxt;
    logic             clk_out_q, clk_out_nxt;
    logic             tick_q, tick_nxt;
    logic [CNT_W-1:0] preset;
    logic             boundary;

    always_comb begin
        preset = P0;
        case (bus.sel)
            2'd0:    preset = P0;
            2'd1:    preset = P1;
            2'd2:    preset = P2;
            default: preset = P3;
        endcase
    end

    // Counter is compared against the latched H, never the live preset, so it cannot overrun.
    assign boundary = (counter_q == div_act_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        counter_nxt = counter_q;
        div_act_nxt = div_act_q;
        clk_out_nxt = PULSE ? 1'b0 : clk_out_q;
        tick_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                counter_nxt = '0;
                clk_out_nxt = 1'b0;
                div_act_nxt = preset;
                if (bus.en) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (!bus.en && (PULSE || !clk_out_q)) begin
                    // Output is already low, so stopping now cannot shorten a high phase.
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                    clk_out_nxt = 1'b0;
                end else if (boundary) begin
                    counter_nxt = '0;
                    div_act_nxt = preset;
                    if (PULSE) begin
                        clk_out_nxt = 1'b1;
                        tick_nxt    = 1'b1;
                    end else begin
                        clk_out_nxt = ~clk_out_q;
                        tick_nxt    = ~clk_out_q;
                    end
                    if (!bus.en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    counter_nxt = counter_q + CNT_W'(1);
                    if (!bus.en) begin
                        state_nxt = STOP;
                    end
                end
            end

            STOP: begin
                if (boundary) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                    div_act_nxt = preset;
                    clk_out_nxt = 1'b0;
                end else begin
                    counter_nxt = counter_q + CNT_W'(1);
                end
            end

            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
                clk_out_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            div_act_q <= P0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            counter_q <= counter_nxt;
            div_act_q <= div_act_nxt;
            clk_out_q <= clk_out_nxt;
            tick_q    <= tick_nxt;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.running = (state_q != IDLE);
    assign bus.div_act = div_act_q;

endmodule
